// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int unsigned DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select: keep, sequential step, aligned redirect target or parked pending target.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] pending_pc,
  output logic [ADDR_W-1:0] redirect_tgt,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    // Low two bits of a redirect are dropped so fetches stay word aligned.
    redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    pc_next      = pc;
    case (sel)
      PC_SEQ:   pc_next = pc + ADDR_W'(PC_STEP);
      PC_REDIR: pc_next = redirect_tgt;
      PC_PEND:  pc_next = pending_pc;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs one imem request at a time and
// hands each fetched word to decode, with redirect, backpressure and halt handling.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: imem_req/imem_addr hold until the cycle imem_ack is seen high;
  // out_valid/out_instr/out_pc hold until a cycle with out_valid && out_ready.

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic [1:0]         issue_state;
  pc_sel_e            pc_sel;

  fetch_pc_next #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .sel          (pc_sel),
    .pc           (pc_q),
    .redirect_pc  (redirect_pc),
    .pending_pc   (pending_pc_q),
    .redirect_tgt (redirect_tgt),
    .pc_next      (pc_d)
  );

  always_comb begin
    state_d      = state_q;
    pending_pc_d = pending_pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    pc_sel       = PC_KEEP;
    // halt only matters at the point a fresh request would be issued.
    issue_state  = halt ? ST_IDLE : ST_REQ;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        state_d = issue_state;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_sel  = PC_REDIR;
            state_d = issue_state;
          end else begin
            out_instr_d = imem_rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_sel      = PC_SEQ;
            state_d     = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // Address must not move mid-request; park the target until the ack.
          pending_pc_d = redirect_tgt;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          pc_sel  = redirect_valid ? PC_REDIR : PC_PEND;
          state_d = issue_state;
        end else if (redirect_valid) begin
          pending_pc_d = redirect_tgt;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          pc_sel      = PC_REDIR;
          state_d     = issue_state;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = issue_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed fetch addresses, outputs and accepted stream.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic [1:0]  dbg_state;

  logic        ack_mode;
  int          n_checks;
  int          n_pass;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = ack_mode & imem_req;
  assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

  // Accepted-instruction monitor; inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk)
    if (reset && out_valid && out_ready) acc_q.push_back(out_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    reset          = 1'b0;
    ack_mode       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;

    // Reset state
    #2;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch 0,4,8 with decode always ready
    step();
    check("seq_addr0", imem_addr, 32'h0);
    check("seq_req0", {31'b0, imem_req}, 32'd1);
    step();
    check("seq_valid0", {31'b0, out_valid}, 32'd1);
    check("seq_pc0", out_pc, 32'h0);
    check("seq_instr0", out_instr, 32'hA5A5A5A5);
    check("seq_hold_req0", {31'b0, imem_req}, 32'd0);
    step();
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid_drop", {31'b0, out_valid}, 32'd0);
    step();
    check("seq_pc4", out_pc, 32'h4);
    check("seq_instr4", out_instr, 32'hA5A5A5A1);
    step();
    check("seq_addr8", imem_addr, 32'h8);
    step();
    check("seq_pc8", out_pc, 32'h8);
    check("seq_instr8", out_instr, 32'hA5A5A5AD);

    // Backpressure at out_pc 0x8
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_pc", out_pc, 32'h8);
      check("bp_instr", out_instr, 32'hA5A5A5AD);
      check("bp_req", {31'b0, imem_req}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_next_addr", imem_addr, 32'hC);
    step();
    check("hold_pc_c", out_pc, 32'hC);

    // Redirect while holding 0xC, decode not ready: held instruction flushed
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_addr", imem_addr, 32'h100);
    step();
    check("redir_pc", out_pc, 32'h100);
    step();
    check("redir_next_addr", imem_addr, 32'h104);

    // Redirect to 0x203 during REQ at 0x104, ack delayed
    ack_mode       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    redirect_valid = 1'b0;
    check("drain_state", {30'b0, dbg_state}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("drain_addr", imem_addr, 32'h104);
      check("drain_req", {31'b0, imem_req}, 32'd1);
      check("drain_valid", {31'b0, out_valid}, 32'd0);
      if (i < 2) step();
    end
    ack_mode = 1'b1;
    step();
    check("drain_discard", {31'b0, out_valid}, 32'd0);
    check("drain_target", imem_addr, 32'h200);

    // Redirect coinciding with an ack, then wrap past the top of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    step();
    redirect_valid = 1'b0;
    check("ackredir_valid", {31'b0, out_valid}, 32'd0);
    check("wrap_addr", imem_addr, 32'hFFFFFFFC);
    step();
    check("wrap_pc", out_pc, 32'hFFFFFFFC);
    check("wrap_instr", out_instr, 32'h5A5A5A59);
    step();
    check("wrap_next_addr", imem_addr, 32'h0);
    step();
    check("hold_pc_0", out_pc, 32'h0);

    // Halt: held instruction still drains, no new request
    halt = 1'b1;
    step();
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_busy", {31'b0, busy}, 32'd0);
    check("halt_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("halt_stay_req", {31'b0, imem_req}, 32'd0);
    halt = 1'b0;
    step();
    check("unhalt_addr", imem_addr, 32'h4);
    ack_mode = 1'b0;
    step();
    check("midreq_req", {31'b0, imem_req}, 32'd1);

    // Async reset mid-request, no clock edge before the check
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    ack_mode = 1'b1;
    reset    = 1'b1;
    step();
    check("post_rst_addr", imem_addr, 32'h0);
    out_ready = 1'b0;
    step();
    check("post_rst_pc", out_pc, 32'h0);
    check("post_rst_instr", out_instr, 32'hA5A5A5A5);

    // Scoreboard of instructions decode actually accepted
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'hFFFFFFFC, 32'h0};
    check("acc_count", acc_q.size(), exp_q.size());
    while (exp_q.size() > 0 && acc_q.size() > 0)
      check("acc_pc", acc_q.pop_front(), exp_q.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
